// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame controller: state encoding and width defaults.
package parity_pkg;

    localparam int BW_DATA_DEF = 8;
    localparam int BW_LEN_DEF  = 8;
    localparam int BW_ERR_CNT  = 8;

    localparam logic [BW_ERR_CNT-1:0] ERR_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/parity_frame_ctrl_parity.sv
// Combinational word parity: reduction XOR of one data word.
module parity_frame_ctrl_parity #(
    parameter int BW_DATA = 8
) (
    input  logic [BW_DATA-1:0] data,
    output logic               par
);

    assign par = ^data;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Frame parity checker: accumulates word parity over a frame of i_len beats,
// then reports the frame parity, a mismatch flag and a saturating error count.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_start; frame fields latched on acceptance
// ST_RUN   | accepting beats (i_valid while o_ready) until len beats seen
// ST_CHECK | one-cycle completion: o_done high, o_par/o_err just updated
module parity_frame_ctrl
    import parity_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEF,
    parameter int BW_LEN  = BW_LEN_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [BW_LEN-1:0]     i_len,
    input  logic                  i_odd,
    input  logic                  i_exp_par,
    input  logic [BW_DATA-1:0]    i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_par,
    output logic                  o_err,
    output logic [BW_ERR_CNT-1:0] o_err_cnt
);

    state_t                  state;
    state_t                  state_next;
    logic [BW_LEN-1:0]       len_q;
    logic [BW_LEN-1:0]       cnt;
    logic                    odd_q;
    logic                    exp_q;
    logic                    acc;
    logic                    par_q;
    logic                    err_q;
    logic [BW_ERR_CNT-1:0]   err_cnt;

    logic                    word_par;
    logic                    beat;
    logic                    last_beat;
    logic                    enter_check;
    logic                    par_next;
    logic                    exp_sel;
    logic                    err_next;

    parity_frame_ctrl_parity #(
        .BW_DATA (BW_DATA)
    ) u_parity (
        .data (i_data),
        .par  (word_par)
    );

    assign beat      = i_valid && (state == ST_RUN);
    assign last_beat = beat && (cnt == (len_q - BW_LEN'(1)));
    assign err_next  = par_next ^ exp_sel;

    always_comb begin
        state_next  = state;
        enter_check = 1'b0;
        par_next    = 1'b0;
        exp_sel     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_len == '0) begin
                        // Empty frame: parity is just the mode bit.
                        state_next  = ST_CHECK;
                        enter_check = 1'b1;
                        par_next    = i_odd;
                        exp_sel     = i_exp_par;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (last_beat) begin
                    state_next  = ST_CHECK;
                    enter_check = 1'b1;
                    par_next    = acc ^ word_par ^ odd_q;
                    exp_sel     = exp_q;
                end
            end
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            cnt     <= '0;
            odd_q   <= 1'b0;
            exp_q   <= 1'b0;
            acc     <= 1'b0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && i_start) begin
                len_q <= i_len;
                odd_q <= i_odd;
                exp_q <= i_exp_par;
                acc   <= 1'b0;
                cnt   <= '0;
            end else if (beat) begin
                acc <= acc ^ word_par;
                cnt <= cnt + BW_LEN'(1);
            end
            if (enter_check) begin
                par_q <= par_next;
                err_q <= err_next;
                if (err_next && (err_cnt != ERR_CNT_MAX)) begin
                    err_cnt <= err_cnt + BW_ERR_CNT'(1);
                end
            end
        end
    end

    assign o_ready   = (state == ST_RUN);
    assign o_busy    = (state != ST_IDLE);
    assign o_done    = (state == ST_CHECK);
    assign o_par     = par_q;
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt;

endmodule
